weight_pattern_gen: RTL and testbench
=====================================

// Module: weight_pattern_gen
// PURPOSE
//  Inverse of the rd84 8-input ones-counter. Given a target Hamming weight k,
//  emits every N-bit word whose popcount is k, one word per handshake.
//  Output order is strictly increasing numeric order.
//  Feeds exhaustive stimulus into weight-counter netlists in power-aware synthesis
//  evaluation, and regenerates the on-set of any rd84 output bit.
// PARAMETERS
//  N      8  pattern width in bits; legal range 2..16
//  CW     4  weight input width; equals $clog2(N+1)
//  IDX_W  8  out_index width; must hold C(N,N/2)-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request a sweep; sampled only in IDLE
//  weight     in   CW     target popcount k; sampled together with start
//  busy       out  1      high in LOAD and EMIT
//  out_valid  out  1      pattern, out_index and out_last are valid
//  out_ready  in   1      consumer accepts the word when high with out_valid
//  pattern    out  N      current word; popcount == k
//  out_index  out  IDX_W  0-based ordinal of pattern within the sweep
//  out_last   out  1      pattern is the final word, (2^k-1)<<(N-k)
//  done       out  1      1-cycle pulse, cycle after the last word is accepted
//  err        out  1      1-cycle pulse, cycle after start with weight > N
// BEHAVIOUR
//  Reset, async assert, sync release:
//   - state = IDLE
//   - busy, out_valid, out_last, done, err = 0
//   - pattern = 0, out_index = 0
//  States: IDLE, LOAD, EMIT.
//  IDLE:
//   - start=1 and weight<=N: latch k; pattern <= (1<<k)-1, out_index <= 0.
//     Next state LOAD.
//   - start=1 and weight>N: err=1 on the next cycle; stay IDLE; no output.
//   - start=0: stay IDLE.
//  LOAD:
//   - one cycle; compute out_last = (pattern == ((1<<k)-1)<<(N-k)).
//   - Next state EMIT with out_valid=1.
//   - Latency from start to first out_valid is exactly 2 cycles.
//  EMIT:
//   - out_valid=1. pattern, out_index and out_last stay stable while out_ready=0.
//   - Accept (out_valid & out_ready), not last:
//     - pattern <= next combination (Gosper successor): t = p|(p-1);
//       next = (t+1) | (((~t & (t+1)) - 1) >> (ctz(p)+1)).
//     - out_index += 1; out_last is recomputed for the new pattern.
//     - Stay EMIT. Throughput is 1 word/cycle while out_ready=1.
//   - Accept of the last word: out_valid=0; done=1 on the next cycle;
//     next state IDLE. pattern keeps its final value.
//  Weight edge cases:
//   - k=0: single word 0x0, with out_last=1 and out_index=0.
//   - k=N: single word all-ones, with out_last=1.
//  Other rules:
//   - start is ignored while busy=1. A new sweep may start on the cycle done=1.
//   - Successor arithmetic is N+1 bits wide. No word above 2^N-1 is ever emitted.
//   - Word count per sweep = C(N,k). out_index never wraps.
//   - rst_n low mid-sweep aborts immediately: no done pulse, and outputs take reset values.
// TESTING
//  T1 k=2: 28 words 0x03,0x05,0x06,0x09,...,0xC0. out_last only on 0xC0;
//     out_index 0..27; done 1 cycle after the 0xC0 accept.
//  T2 k=0 -> one word 0x00 with out_last=1. k=8 -> one word 0xFF with out_last=1.
//     k=9 -> err pulse; out_valid stays 0.
//  T3 k=4 with random out_ready (~40% duty): 70 words, none dropped or duplicated.
//     Outputs hold while stalled.
//  T4 for every k in 0..8, a popcount (rd84-equivalent) model checks:
//     - every word has popcount k
//     - words are strictly increasing
//     - word count == C(8,k); total across all k = 256
//  T5 start pulsed mid-sweep (k=3, then weight=5) -> ignored; the k=3 sweep completes (56 words).
//  T6 rst_n low at word 10 of a k=4 sweep -> all outputs 0 at once.
//     A following start with k=1 -> 0x01 as its first word.

Source files
------------

// File: rtl/weight_pattern_gen.sv
`default_nettype none
// ============================================================================
// weight_pattern_gen
//   Emits every N-bit word of Hamming weight k, in increasing numeric order,
//   one word per valid/ready handshake.
//   Revision: 1.0
// ============================================================================
module weight_pattern_gen #(
  parameter int N     = 8,
  parameter int CW    = 4,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    weight,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pattern,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam logic [CW:0]  c_N   = (CW+1)'(N);
  localparam logic [N:0]   c_ONE = (N+1)'(1);
  localparam logic [CW:0]  c_SH1 = (CW+1)'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_k;
  logic [N-1:0]     r_pattern;
  logic [IDX_W-1:0] r_index;
  logic             r_last;
  logic             r_done;
  logic             r_err;

  logic             w_weight_ok;
  logic [N-1:0]     w_init;
  logic [N-1:0]     w_ones_k;
  logic [N-1:0]     w_mask;
  logic             w_is_last_cur;
  logic             w_is_last_succ;

  logic [N:0]       w_p;
  logic [N:0]       w_t;
  logic [N:0]       w_t1;
  logic [N:0]       w_low;
  logic [N:0]       w_tail;
  logic [N:0]       w_succ;
  logic [CW-1:0]    w_ctz;
  logic [CW:0]      w_shamt;

  assign w_weight_ok = ({1'b0, weight} <= c_N);

  // Smallest word of weight k: k ones packed at the bottom.
  assign w_init   = ~({N{1'b1}} << weight);

  // Largest word of weight k: k ones packed at the top.
  assign w_ones_k = ~({N{1'b1}} << r_k);
  assign w_mask   = w_ones_k << (c_N - {1'b0, r_k});

  assign w_is_last_cur = (r_pattern == w_mask);

  // Index of the lowest set bit of the current word.
  always_comb begin
    w_ctz = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pattern[i]) begin
        w_ctz = CW'(i);
      end
    end
  end

  // Gosper successor in N+1 bits so the carry out of the top is never lost.
  assign w_p     = {1'b0, r_pattern};
  assign w_t     = w_p | (w_p - c_ONE);
  assign w_t1    = w_t + c_ONE;
  assign w_low   = (~w_t & w_t1) - c_ONE;
  assign w_shamt = {1'b0, w_ctz} + c_SH1;
  assign w_tail  = w_low >> w_shamt;
  assign w_succ  = w_t1 | w_tail;

  assign w_is_last_succ = (w_succ == {1'b0, w_mask});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_weight_ok) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy        = 1'b1;
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && r_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_pattern <= '0;
      r_index   <= '0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_weight_ok) begin
              r_k       <= weight;
              r_pattern <= w_init;
              r_index   <= '0;
              r_last    <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_last <= w_is_last_cur;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_last) begin
              r_done <= 1'b1;
            end else begin
              r_pattern <= w_succ[N-1:0];
              r_index   <= r_index + IDX_W'(1);
              r_last    <= w_is_last_succ;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pattern   = r_pattern;
  assign out_index = r_index;
  assign out_last  = r_last;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_weight_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_weight_pattern_gen
//   Scoreboard bench: expected words are enumerated from the weight rule and
//   compared by an independent monitor on every accepted handshake.
//   Revision: 1.0
// ============================================================================
module tb_weight_pattern_gen;

  localparam int N     = 8;
  localparam int CW    = 4;
  localparam int IDX_W = 8;
  localparam int LIMIT = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CW-1:0]    weight = '0;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             out_valid;
  logic [N-1:0]     pattern;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             done;
  logic             err;

  weight_pattern_gen #(.N(N), .CW(CW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight(weight),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .pattern(pattern), .out_index(out_index), .out_last(out_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     p;
    logic [IDX_W-1:0] idx;
    logic             last;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    accepted = 0;
  int    cur_k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Reference: scan all N-bit values in order, keep those with k ones.
  task automatic build_expected(input int k);
    int idx = 0;
    item_t it;
    for (int v = 0; v < (1 << N); v++) begin
      if ($countones(v[N-1:0]) == k) begin
        it.p    = v[N-1:0];
        it.idx  = IDX_W'(idx);
        it.last = 1'b0;
        q.push_back(it);
        idx++;
      end
    end
    if (q.size() > 0) q[q.size()-1].last = 1'b1;
  endtask

  // Monitor: samples on the falling edge, between driver updates.
  logic             last_acc = 1'b0;
  logic             have_hold = 1'b0;
  logic [N+IDX_W:0] hold = '0;
  logic [N-1:0]     prev_pat = '0;

  always @(negedge clk) begin
    item_t e;
    if (!rst_n) begin
      last_acc  = 1'b0;
      have_hold = 1'b0;
    end else begin
      if (last_acc || done) chk("done_pulse", 64'(done), 64'(last_acc));
      last_acc = 1'b0;
      if (have_hold && out_valid)
        chk("stall_hold", 64'({pattern, out_index, out_last}), 64'(hold));
      have_hold = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", pattern, $time);
        end else begin
          e = q.pop_front();
          chk("word", 64'({pattern, out_index, out_last}), 64'(e));
          chk("popcount", 64'($countones(pattern)), 64'(cur_k));
          if (out_index != 0) chk("increasing", 64'(pattern > prev_pat), 64'(1));
        end
        prev_pat = pattern;
        accepted++;
        last_acc = out_last;
      end else if (out_valid) begin
        have_hold = 1'b1;
        hold      = {pattern, out_index, out_last};
      end
    end
  end

  task automatic sweep(input int k, input int duty, input int mid_at);
    int cycles = 0;
    cur_k    = k;
    accepted = 0;
    build_expected(k);
    weight = CW'(k);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_load", 64'(busy), 64'(1));
    chk("valid_load", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("first_valid", 64'(out_valid), 64'(1));
    chk("first_word", 64'(pattern), 64'(q[0].p));
    while (!done && cycles < LIMIT) begin
      if (cycles == mid_at) begin
        start  = 1'b1;
        weight = CW'(5);
      end else begin
        start = 1'b0;
      end
      out_ready = ($urandom_range(99) < duty);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk("sweep_in_time", 64'(cycles < LIMIT), 64'(1));
    chk("word_count", 64'(accepted), 64'(binom(N, k)));
    chk("queue_empty", 64'(q.size()), 64'(0));
    chk("idle_at_done", 64'(busy), 64'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out"}, 64'({busy, out_valid, pattern, out_index, out_last, done, err}), 64'(0));
  endtask

  initial begin
    int total = 0;
    int cycles = 0;

    #12;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Weight 2 with full throughput
    sweep(2, 100, -1);

    // Single-word edge weights
    sweep(0, 100, -1);
    sweep(N, 100, -1);

    // Illegal weight
    weight = CW'(N + 1);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'(1));
    chk("err_no_valid", 64'({busy, out_valid}), 64'(0));
    @(posedge clk); #1;
    chk("err_clears", 64'(err), 64'(0));
    chk("err_still_idle", 64'({busy, out_valid}), 64'(0));

    // Back-pressure
    sweep(4, 40, -1);

    // All weights; totals must cover every N-bit word
    for (int k = 0; k <= N; k++) begin
      sweep(k, 70, -1);
      total += accepted;
    end
    chk("total_words", 64'(total), 64'(1 << N));

    // Start pulsed mid-sweep is ignored
    sweep(3, 100, 7);

    // Reset mid-sweep
    cur_k    = 4;
    accepted = 0;
    build_expected(4);
    weight    = CW'(4);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (!(out_valid && out_index == IDX_W'(10)) && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("reach_word10", 64'(out_index), 64'(10));
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_done_after_reset", 64'({done, busy}), 64'(0));
    sweep(1, 100, -1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
